// File: rtl/voxel_grid_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// voxel_grid_port_arbiter_if
// Requester-side bus of the voxel grid port arbiter. The three requesters
// (bit0 creator, bit1 clustering, bit2 refiner) are packed side by side.
//   req_valid / req_we  : per-requester request and write enable
//   req_addr            : requester i at [i*ADDR_W +: ADDR_W]
//   req_wdata           : requester i at [i*DATA_W +: DATA_W]
//   req_grant           : one-hot, access accepted this cycle
//   rd_valid            : one-hot, rd_data belongs to that requester
//   rd_data             : shared read data
// master = requester side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface voxel_grid_port_arbiter_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 80
);
  logic [2:0]          req_valid;
  logic [2:0]          req_we;
  logic [3*ADDR_W-1:0] req_addr;
  logic [3*DATA_W-1:0] req_wdata;
  logic [2:0]          req_grant;
  logic [2:0]          rd_valid;
  logic [DATA_W-1:0]   rd_data;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_grant, rd_valid, rd_data
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_grant, rd_valid, rd_data
  );
endinterface

// File: rtl/voxel_grid_port_arbiter.sv
// ---------------------------------------------------------------------------
// voxel_grid_port_arbiter
// Shares one single-port voxel grid BRAM between three requesters with
// round-robin arbitration (one access per cycle) and zeroes the whole grid
// on clear_start.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   clear_start         pulse: zero words 0..DEPTH-1
//   clear_busy          clear engine owns the port
//   clear_done          one-cycle pulse after the last clear write
//   bus                 requester bus (voxel_grid_port_arbiter_if.slave)
//   mem_en, mem_we      BRAM enable / write enable
//   mem_addr, mem_wdata BRAM address / write data
//   mem_rdata           BRAM read data, one cycle after mem_en
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_ARB  | round-robin arbitration, grant and BRAM controls combinational
// ST_CLEAR| clear engine writes zero to address clr_cnt_q every cycle
// ---------------------------------------------------------------------------
module voxel_grid_port_arbiter #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 80,
  parameter int DEPTH  = 32768
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear_start,
  output logic                       clear_busy,
  output logic                       clear_done,
  voxel_grid_port_arbiter_if.slave   bus,
  output logic                       mem_en,
  output logic                       mem_we,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  input  logic [DATA_W-1:0]          mem_rdata
);

  typedef enum logic {ST_ARB, ST_CLEAR} state_t;

  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(DEPTH - 1);

  state_t            state_q, state_d;
  logic [1:0]        rr_ptr_q, rr_ptr_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [2:0]        rd_valid_q, rd_valid_d;
  logic              clear_done_q, clear_done_d;

  logic [1:0]        cand0, cand1, cand2;
  logic [1:0]        win_idx;
  logic              win_any;
  logic [2:0]        grant;

  // Search order starts one past the last winner and wraps modulo 3.
  always_comb begin
    cand0 = (rr_ptr_q >= 2'd2) ? 2'd0 : rr_ptr_q + 2'd1;
    cand1 = (cand0 == 2'd2) ? 2'd0 : cand0 + 2'd1;
    cand2 = (cand1 == 2'd2) ? 2'd0 : cand1 + 2'd1;
    win_any = 1'b1;
    win_idx = cand0;
    if (bus.req_valid[cand0]) begin
      win_idx = cand0;
    end else if (bus.req_valid[cand1]) begin
      win_idx = cand1;
    end else if (bus.req_valid[cand2]) begin
      win_idx = cand2;
    end else begin
      win_any = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_ARB;
      rr_ptr_q     <= 2'd2;
      clr_cnt_q    <= '0;
      rd_valid_q   <= '0;
      clear_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      clr_cnt_q    <= clr_cnt_d;
      rd_valid_q   <= rd_valid_d;
      clear_done_q <= clear_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    clr_cnt_d    = clr_cnt_q;
    rd_valid_d   = '0;
    clear_done_d = 1'b0;
    grant        = '0;
    mem_en       = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    // The combinational port controls must also read as idle while reset is
    // held, not just after the registers have cleared.
    if (rst_n) begin
      unique case (state_q)
        ST_ARB: begin
          if (clear_start) begin
            state_d   = ST_CLEAR;
            clr_cnt_d = '0;
          end else if (win_any) begin
            grant     = 3'b001 << win_idx;
            mem_en    = 1'b1;
            mem_we    = bus.req_we[win_idx];
            mem_addr  = bus.req_addr[win_idx*ADDR_W +: ADDR_W];
            mem_wdata = bus.req_wdata[win_idx*DATA_W +: DATA_W];
            rr_ptr_d  = win_idx;
            if (!bus.req_we[win_idx]) begin
              rd_valid_d = grant;
            end
          end
        end
        ST_CLEAR: begin
          mem_en   = 1'b1;
          mem_we   = 1'b1;
          mem_addr = clr_cnt_q;
          if (clr_cnt_q == CLR_LAST) begin
            state_d      = ST_ARB;
            clr_cnt_d    = '0;
            clear_done_d = 1'b1;
          end else begin
            clr_cnt_d = clr_cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_ARB;
        end
      endcase
    end
  end

  assign bus.req_grant = grant;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = mem_rdata;
  assign clear_busy    = (state_q == ST_CLEAR);
  assign clear_done    = clear_done_q;

endmodule

// File: tb/tb_voxel_grid_port_arbiter.sv
module tb_voxel_grid_port_arbiter;
  localparam int ADDR_W = 15;
  localparam int DATA_W = 80;
  localparam int DEPTH  = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear_start;
  logic clear_busy, clear_done;
  logic mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;

  always #5 clk = ~clk;

  voxel_grid_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  voxel_grid_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_start(clear_start),
    .clear_busy (clear_busy),
    .clear_done (clear_done),
    .bus        (bus.slave),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  function automatic logic [DATA_W-1:0] init_word(input int a);
    return {16'hC0DE, 32'(a) ^ 32'hDEAD_BEEF, 32'(a)};
  endfunction

  // BRAM model: unwritten words hold init_word(addr)
  logic [DATA_W-1:0] bram [int];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) bram[int'(mem_addr)] = mem_wdata;
      else mem_rdata <= bram.exists(int'(mem_addr)) ? bram[int'(mem_addr)] : init_word(int'(mem_addr));
    end
  end

  // Bench's own record of what each word should contain
  logic [DATA_W-1:0] shadow [int];
  function automatic logic [DATA_W-1:0] exp_word(input int a);
    return shadow.exists(a) ? shadow[a] : init_word(a);
  endfunction

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]        oh;
    logic [DATA_W-1:0] data;
    int                due;
  } sb_t;
  sb_t sb_q[$];
  sb_t mon_e;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
        mon_e = sb_q.pop_front();
        check_eq("rd_valid", bus.rd_valid, mon_e.oh);
        check_eq("rd_data", bus.rd_data, mon_e.data);
      end else if (bus.rd_valid != 3'b000) begin
        check_eq("rd_unexpected", bus.rd_valid, 3'b000);
      end
    end
  end

  task automatic set_req(input int i, input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd);
    bus.req_we[i] = we;
    bus.req_addr[i*ADDR_W +: ADDR_W] = a;
    bus.req_wdata[i*DATA_W +: DATA_W] = wd;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Checks the grant of the current cycle and queues the expected read data.
  task automatic expect_grant(input string tag, input logic [2:0] oh);
    int i;
    logic [ADDR_W-1:0] a;
    check_eq({tag, "_grant"}, bus.req_grant, oh);
    check_eq({tag, "_en"}, mem_en, |oh);
    if (oh != 3'b000) begin
      i = oh[0] ? 0 : (oh[1] ? 1 : 2);
      a = bus.req_addr[i*ADDR_W +: ADDR_W];
      check_eq({tag, "_addr"}, mem_addr, a);
      check_eq({tag, "_we"}, mem_we, bus.req_we[i]);
      if (bus.req_we[i]) begin
        check_eq({tag, "_wdata"}, mem_wdata, bus.req_wdata[i*DATA_W +: DATA_W]);
        shadow[int'(a)] = bus.req_wdata[i*DATA_W +: DATA_W];
      end else begin
        sb_t e;
        e.oh   = oh;
        e.data = exp_word(int'(a));
        e.due  = cyc + 1;
        sb_q.push_back(e);
      end
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_grant"}, bus.req_grant, 3'b000);
    check_eq({tag, "_rdv"}, bus.rd_valid, 3'b000);
    check_eq({tag, "_busy"}, clear_busy, 1'b0);
    check_eq({tag, "_done"}, clear_done, 1'b0);
    check_eq({tag, "_en"}, mem_en, 1'b0);
    check_eq({tag, "_we"}, mem_we, 1'b0);
    check_eq({tag, "_addr"}, mem_addr, '0);
    check_eq({tag, "_wdata"}, mem_wdata, '0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
  endtask

  localparam logic [DATA_W-1:0] WD = 80'h5A3C_96F0_1234_5678_9AA5;

  initial begin
    clear_start = 1'b0;
    bus.req_valid = 3'b111;
    bus.req_we = '0;
    bus.req_addr = '0;
    bus.req_wdata = '0;

    // reset values with all requesters asserting
    #12;
    check_idle_outputs("reset");
    bus.req_valid = 3'b000;
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();

    // single read by clustering
    set_req(1, 1'b0, 15'h0123, '0);
    bus.req_valid = 3'b010;
    sample();
    expect_grant("single_rd", 3'b010);
    next_cycle();
    bus.req_valid = 3'b000;
    sample();
    expect_grant("idle", 3'b000);
    next_cycle();

    // round-robin from a fresh reset
    do_reset();
    set_req(0, 1'b0, 15'h0010, '0);
    set_req(1, 1'b0, 15'h0020, '0);
    set_req(2, 1'b0, 15'h0030, '0);
    bus.req_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      sample();
      expect_grant("rr", 3'b001 << (k % 3));
      next_cycle();
    end
    bus.req_valid = 3'b000;
    sample();
    next_cycle();

    // write then read back 0x7FFF
    set_req(0, 1'b1, 15'h7FFF, WD);
    bus.req_valid = 3'b001;
    sample();
    expect_grant("wr", 3'b001);
    next_cycle();
    set_req(0, 1'b0, 15'h7FFF, '0);
    sample();
    expect_grant("rdback", 3'b001);
    next_cycle();
    bus.req_valid = 3'b000;
    sample();
    next_cycle();

    // clear with all three requesting, plus a second clear_start mid-clear
    set_req(0, 1'b0, 15'h0003, '0);
    set_req(1, 1'b0, 15'h0005, '0);
    set_req(2, 1'b0, 15'h000F, '0);
    bus.req_valid = 3'b111;
    clear_start = 1'b1;
    sample();
    check_eq("clr_T_grant", bus.req_grant, 3'b000);
    check_eq("clr_T_en", mem_en, 1'b0);
    check_eq("clr_T_busy", clear_busy, 1'b0);
    next_cycle();
    for (int k = 0; k < DEPTH; k++) begin
      clear_start = (k == 4);
      sample();
      check_eq("clr_grant", bus.req_grant, 3'b000);
      check_eq("clr_busy", clear_busy, 1'b1);
      check_eq("clr_en", mem_en, 1'b1);
      check_eq("clr_we", mem_we, 1'b1);
      check_eq("clr_addr", mem_addr, ADDR_W'(k));
      check_eq("clr_wdata", mem_wdata, '0);
      check_eq("clr_done_early", clear_done, 1'b0);
      next_cycle();
    end
    clear_start = 1'b0;
    for (int a = 0; a < DEPTH; a++) shadow[a] = '0;
    sample();
    check_eq("clr_done", clear_done, 1'b1);
    check_eq("clr_busy_end", clear_busy, 1'b0);
    expect_grant("post_clr", 3'b010);
    next_cycle();
    bus.req_valid = 3'b000;
    sample();
    check_eq("clr_done_pulse", clear_done, 1'b0);
    next_cycle();

    // read back every cleared word through the refiner
    bus.req_valid = 3'b100;
    for (int a = 0; a < DEPTH; a++) begin
      set_req(2, 1'b0, ADDR_W'(a), '0);
      sample();
      expect_grant("clr_rd", 3'b100);
      next_cycle();
    end
    bus.req_valid = 3'b000;
    sample();
    next_cycle();

    // async reset while the clear engine is at address 8
    clear_start = 1'b1;
    sample();
    next_cycle();
    clear_start = 1'b0;
    for (int k = 0; k < 9; k++) begin
      sample();
      if (k < 8) next_cycle();
    end
    check_eq("rst_clr_addr8", mem_addr, ADDR_W'(8));
    #2;
    rst_n = 1'b0;
    bus.req_valid = 3'b111;
    #1;
    check_idle_outputs("rst_mid");
    repeat (3) begin
      sample();
      check_eq("rst_hold_done", clear_done, 1'b0);
      check_eq("rst_hold_grant", bus.req_grant, 3'b000);
    end
    bus.req_valid = 3'b000;
    #2;
    rst_n = 1'b1;
    next_cycle();
    set_req(0, 1'b0, 15'h0100, '0);
    set_req(1, 1'b0, 15'h0200, '0);
    set_req(2, 1'b0, 15'h0300, '0);
    bus.req_valid = 3'b111;
    sample();
    check_eq("post_rst_done", clear_done, 1'b0);
    check_eq("post_rst_busy", clear_busy, 1'b0);
    expect_grant("post_rst", 3'b001);
    next_cycle();
    bus.req_valid = 3'b000;
    sample();
    check_eq("post_rst_done2", clear_done, 1'b0);
    next_cycle();
    sample();

    check_eq("sb_drain", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/voxel_grid_port_arbiter.md
# voxel_grid_port_arbiter

Single-port voxel grid BRAM arbiter and clear sequencer for the LiDAR feature extractor. Shares one 80-bit voxel grid port between three requesters: voxel grid creator (read/write), clustering (read), segment refiner scan (read). Round-robin arbitration, one access per cycle. Embedded clear engine zeroes the whole grid on command before each frame.

## Interface
- ADDR_W, 15, voxel address width (32x32x32 grid)
- DATA_W, 80, voxel word width
- DEPTH, 32768, number of words cleared by the clear engine (must be ≤ 2^ADDR_W)
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- clear_start  in  1  one-cycle pulse: zero entire grid
- clear_busy  out  1  high while clear engine owns the port
- clear_done  out  1  one-cycle pulse after last clear write
- req_valid  in  3  per-requester access request (bit0 creator, bit1 clustering, bit2 refiner)
- req_we  in  3  per-requester write enable (qualifies req_valid)
- req_addr  in  3*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  3*DATA_W  packed write data, same packing
- req_grant  out  3  one-hot; access accepted this cycle
- rd_valid  out  3  one-hot; rd_data valid for that requester
- rd_data  out  DATA_W  read data, shared
- mem_en, mem_we  out  1 each  BRAM enable / write enable
- mem_addr  out  ADDR_W  BRAM address
- mem_wdata  out  DATA_W  BRAM write data
- mem_rdata  in  DATA_W  BRAM read data, 1-cycle latency after mem_en

## Operation
- States: ARB, CLEAR. Reset -> ARB.
- ARB: among asserted req_valid bits, grant the first at or after (rr_ptr+1) mod 3. req_grant combinational in same cycle; mem_en/mem_we/mem_addr/mem_wdata driven combinationally from winner. rr_ptr <= winner index on grant. Reset rr_ptr = 2 (requester 0 highest priority first).
- Requester holds valid/we/addr/wdata stable until its grant bit is seen; grant = transfer. No grant when no request; mem_en = 0.
- Read grant (req_we=0) at cycle T -> rd_valid[i] = 1 at T+1, rd_data = mem_rdata at T+1. Write grant produces no rd_valid.
- clear_start high in ARB: no grant that cycle (req_grant=0, mem_en=0); next state CLEAR, clear address counter = 0.
- CLEAR: req_grant = 0. Each cycle mem_en=1, mem_we=1, mem_wdata=0, mem_addr=counter; counter++. After write to DEPTH-1 -> ARB; clear_done pulses in the first ARB cycle; arbitration resumes in that same cycle.
- clear_start during CLEAR ignored (no restart, no extension).
- rd_valid for a read granted the cycle before clear_start still issues normally.
- Async reset mid-operation: immediate return to ARB, counter cleared, no clear_done, pending rd_valid dropped; BRAM contents undefined.

## Timing
- Reset values: req_grant=0, rd_valid=0, clear_busy=0, clear_done=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, rd_data follows mem_rdata (don't care).
- Access latency: grant 0 cycles after valid when port free; read data 1 cycle after grant.
- Throughput: 1 access/cycle; with all three requesting continuously, each granted every 3rd cycle.
- Clear: clear_start at T -> clear_busy high T+1..T+DEPTH, writes addr 0..DEPTH-1 in those cycles, clear_done at T+DEPTH+1.
- Registered: state, rr_ptr, clear counter, rd_valid, clear_done. Combinational: req_grant, mem_* in ARB.

## Test plan
- Single read: req_valid=3'b010, addr=0x0123 -> req_grant=3'b010 same cycle, mem_addr=0x0123; next cycle rd_valid=3'b010, rd_data = BRAM model word.
- Round-robin: req_valid held 3'b111 after reset for 6 cycles -> grants 001,010,100,001,010,100; each rd_valid one cycle behind.
- Write/read-back: creator writes 80'h5A..A5 to 0x7FFF, then reads 0x7FFF -> rd_valid[0] with same data.
- Clear with DEPTH=16: clear_start at T while req_valid=3'b111 -> grant 0 at T..T+16, mem_we=1 addr 0..15 at T+1..T+16, clear_done at T+17 with a grant in that cycle; all words read back 0.
- clear_start pulsed again mid-clear -> done timing unchanged (T+17).
- rst_n low at clear address 8 -> all outputs to reset values immediately, no clear_done; after release, single read works normally with requester 0 first priority.
